// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg: instruction encoding, opcode/fault enums and field accessors
package program_sequencer_pkg;
  typedef logic [31:0] instruction_t;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_JUMP = 4'd1,
    OP_UNL  = 4'd2,
    OP_CALL = 4'd3,
    OP_RET  = 4'd4,
    OP_HALT = 4'd5
  } opcode_t;
  typedef enum logic [1:0] {
    FAULT_NONE      = 2'd0,
    FAULT_OVERFLOW  = 2'd1,
    FAULT_UNDERFLOW = 2'd2
  } fault_code_t;
  function automatic opcode_t get_opcode(instruction_t i);
    return opcode_t'(i[31:28]);
  endfunction
  function automatic logic [15:0] get_jump_addr(instruction_t i);
    return i[15:0];
  endfunction
  function automatic logic signed [15:0] get_rel_branch_addr(instruction_t i);
    return $signed(i[15:0]);
  endfunction
endpackage

// File: rtl/program_sequencer_if.sv
// program_sequencer_if: instruction/control inputs and PC/stack/status outputs of the sequencer
interface program_sequencer_if
  import program_sequencer_pkg::*;
#(
  parameter int PC_W        = 16,
  parameter int STACK_DEPTH = 32
);
  instruction_t                   instruction;
  logic                           diverge_consensus;
  logic                           stall;
  logic                           resume;
  logic [PC_W-1:0]                program_counter;
  logic [PC_W-1:0]                next_program_counter;
  logic [$clog2(STACK_DEPTH):0]   stack_level;
  logic                           halted;
  logic                           fault;
  fault_code_t                    fault_code;
  modport master (
    output instruction, diverge_consensus, stall, resume,
    input  program_counter, next_program_counter, stack_level, halted, fault, fault_code
  );
  modport slave (
    input  instruction, diverge_consensus, stall, resume,
    output program_counter, next_program_counter, stack_level, halted, fault, fault_code
  );
endinterface

// File: rtl/program_sequencer_call_stack.sv
// call_stack: return-address storage and level counter; PROGRAM_SEQUENCER_STACK_CHECK_EN adds full/empty and a saturating-range level, otherwise the level wraps
module call_stack #(
  parameter int PC_W        = 16,
  parameter int STACK_DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PC_W-1:0]              push_data,
  output logic [PC_W-1:0]              pop_data,
  output logic [$clog2(STACK_DEPTH):0] level
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
  ,
  output logic                         full,
  output logic                         empty
`endif
);
  localparam int IW = $clog2(STACK_DEPTH);
  localparam int LW = IW + 1;
  logic [PC_W-1:0] mem_q [STACK_DEPTH];
  logic [LW-1:0]   level_q, level_d;
  logic [IW-1:0]   top;
  assign top      = level_q[IW-1:0];
  assign pop_data = mem_q[top - IW'(1)];
  assign level    = level_q;
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
  assign full  = level_q == LW'(STACK_DEPTH);
  assign empty = level_q == '0;
`endif
  // Next level: count entries up on push, down on pop
  always_comb begin
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
    level_d = push ? level_q + LW'(1) : pop ? level_q - LW'(1) : level_q;
`else
    level_d = {1'b0, push ? top + IW'(1) : pop ? top - IW'(1) : top};
`endif
  end
  // Level register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= level_d;
  end
  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem_q[top] <= push_data;
  end
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: PC and call/return sequencing with stall, halt/resume; PROGRAM_SEQUENCER_STACK_CHECK_EN enables the sticky stack FAULT state
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int PC_W        = 16,
  parameter int STACK_DEPTH = 32,
  parameter int PC_INC      = 2
) (
  input logic               clk,
  input logic               rst_n,
  program_sequencer_if.slave bus
);
  localparam int LW = $clog2(STACK_DEPTH) + 1;
  typedef enum logic [1:0] {
    S_RUN,
    S_HALTED
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
    ,
    S_FAULT
`endif
  } seq_state_t;
  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, pc_rel, pop_data;
  logic            halted_q;
  logic            push, pop;
  logic [LW-1:0]   level;
  opcode_t         op;
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
  logic            full, empty, fault_q;
  fault_code_t     fc_q, fc_d;
`endif
  assign op     = get_opcode(bus.instruction);
  assign pc_inc = pc_q + PC_W'(PC_INC);
  assign pc_rel = pc_q + PC_W'(get_rel_branch_addr(bus.instruction));
  call_stack #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .pop_data  (pop_data),
    .level     (level)
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
    ,
    .full      (full),
    .empty     (empty)
`endif
  );
  // Resolve next PC, state and stack action; stall freezes everything
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
    fc_d    = fc_q;
`endif
    if (!bus.stall) begin
      case (state_q)
        S_RUN: begin
          case (op)
            OP_JUMP: pc_d = PC_W'(get_jump_addr(bus.instruction));
            OP_UNL:  pc_d = bus.diverge_consensus ? pc_rel : pc_inc;
            OP_CALL: begin
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
              if (full) begin
                state_d = S_FAULT;
                fc_d    = FAULT_OVERFLOW;
              end else begin
                pc_d = PC_W'(get_jump_addr(bus.instruction));
                push = 1'b1;
              end
`else
              pc_d = PC_W'(get_jump_addr(bus.instruction));
              push = 1'b1;
`endif
            end
            OP_RET: begin
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
              if (empty) begin
                state_d = S_FAULT;
                fc_d    = FAULT_UNDERFLOW;
              end else begin
                pc_d = pop_data;
                pop  = 1'b1;
              end
`else
              pc_d = pop_data;
              pop  = 1'b1;
`endif
            end
            OP_HALT: state_d = S_HALTED;
            default: pc_d = pc_inc;
          endcase
        end
        S_HALTED: begin
          pc_d    = bus.resume ? pc_inc : pc_q;
          state_d = bus.resume ? S_RUN : S_HALTED;
        end
        default: ;
      endcase
    end
  end
  // The HALT instruction advertises its return address while the PC itself holds
  assign bus.next_program_counter = (!bus.stall && state_q == S_RUN && op == OP_HALT) ? pc_inc : pc_d;
  // State machine with registered PC and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      pc_q     <= '0;
      halted_q <= 1'b0;
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
      fault_q  <= 1'b0;
      fc_q     <= FAULT_NONE;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= state_d == S_HALTED;
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
      fault_q  <= state_d == S_FAULT;
      fc_q     <= fc_d;
`endif
    end
  end
  assign bus.program_counter = pc_q;
  assign bus.stack_level     = level;
  assign bus.halted          = halted_q;
`ifdef PROGRAM_SEQUENCER_STACK_CHECK_EN
  assign bus.fault           = fault_q;
  assign bus.fault_code      = fc_q;
`else
  assign bus.fault           = 1'b0;
  assign bus.fault_code      = FAULT_NONE;
`endif
endmodule

// File: doc/program_sequencer.md
# program_sequencer

Parametrised instruction sequencer for the cellular-automaton processor. It holds the program counter and a configurable-depth hardware call stack, and resolves JUMP, UNL, CALL, RET and HALT each cycle. It adds pipeline stall, halt/resume and stack fault detection. It sits between instruction fetch and the lane array, and consumes `diverge_consensus` from the lanes.

## Interface
- `PC_W`, default 16: program counter width in bits.
- `STACK_DEPTH`, default 32: call stack entries; must be ≥2 and a power of two.
- `PC_INC`, default 2: byte increment per sequential instruction.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `instruction`  in  `instruction_t`  current instruction; decoded with the `isa` accessors.
- `diverge_consensus`  in  1  all lanes agree; UNL takes the branch when high.
- `stall`  in  1  freeze all sequencer state this cycle.
- `resume`  in  1  one-cycle pulse that leaves HALTED.
- `program_counter`  out  `PC_W`  registered PC.
- `next_program_counter`  out  `PC_W`  value the PC takes at the next edge (combinational).
- `stack_level`  out  `$clog2(STACK_DEPTH)+1`  occupied stack entries (registered).
- `halted`  out  1  high while in HALTED.
- `fault`  out  1  high while in FAULT.
- `fault_code`  out  2  `FAULT_NONE`=0, `FAULT_OVERFLOW`=1, `FAULT_UNDERFLOW`=2.

## Operation
- State machine has three states: RUN, HALTED, FAULT. Reset enters RUN.
- In RUN with `stall`=0, `next_program_counter` is selected by opcode:
  - JUMP → `jump_addr`.
  - UNL → `program_counter + sext(rel_branch_addr)` if `diverge_consensus`, else `program_counter + PC_INC`.
  - CALL → `jump_addr`; pushes `program_counter + PC_INC`; `stack_level` increments by 1.
  - RET → top entry; pops; `stack_level` decrements by 1.
  - HALT → `program_counter + PC_INC`; the PC is loaded with this value only on resume. State goes to HALTED.
  - Any other opcode → `program_counter + PC_INC`.
- Stack level counts entries, not bytes. The push writes entry `stack_level`; the pop reads entry `stack_level-1`.
- All PC arithmetic is modulo 2^`PC_W`. The branch offset is sign-extended to `PC_W`.
- Fault conditions:
  - CALL with `stack_level==STACK_DEPTH` is an overflow.
  - RET with `stack_level==0` is an underflow.
  - On either, the sequencer enters FAULT with no push or pop. PC and level hold, and `fault_code` is set.
- In HALTED, PC and level hold. `resume`=1 with `stall`=0 loads PC with `program_counter + PC_INC` and returns to RUN.
- FAULT is sticky and is left only by reset.
- `stall`=1 blocks all updates: no PC change, no push or pop, no state change, `resume` ignored, no fault raised. `stall` takes priority over every other event.
- `resume` outside HALTED is ignored.
- While stalled, halted or faulted, `next_program_counter` equals `program_counter`; while HALTED with `resume`=1 and `stall`=0 it equals `program_counter + PC_INC`.
- Reset values: `program_counter`=0, `stack_level`=0, `halted`=0, `fault`=0, `fault_code`=0. Stack contents are not reset.
- Reset asserted mid-operation clears everything immediately; any in-flight push is discarded.

## Timing
- `next_program_counter` is combinational from `instruction`, `diverge_consensus`, `stall`, `resume` and state, with zero latency.
- PC, level and state update on the rising edge following evaluation; one instruction per cycle.
- RET reads the entry pushed by a CALL on the immediately preceding cycle (write-then-read across one edge; no bypass needed).
- `halted` and `fault` assert in the cycle after the triggering edge, i.e. the cycle the HALT or faulting instruction completes.

## Configuration
- `PROGRAM_SEQUENCER_STACK_CHECK_EN`:
  - Defined: overflow and underflow detection as above.
  - Undefined: the FAULT state is not built. `fault` and `fault_code` are tied to 0. `stack_level` wraps modulo `STACK_DEPTH`: overflow overwrites entry 0 and underflow reads entry `STACK_DEPTH-1`.

## Structure
- The `isa` package gains the `HALT` opcode and a `fault_code_t` enum.
- `seq_state_t` is local to the module.
- Sub-module `call_stack`: parametrised by `PC_W` and `STACK_DEPTH`. It contains the storage array and level counter, with push/pop/full/empty ports; the sequencer owns the state machine and PC.

## Test plan
- Reset, then 4 NOPs → PC 0,2,4,6,8; `stack_level`=0; all flags 0.
- CALL 0x40 at PC 0x10, then RET at 0x40 → PC 0x40 then 0x12; level 1 then 0; `next_program_counter` 0x12 during RET.
- UNL with rel=-4 at PC 0x20: consensus=1 → 0x1C; consensus=0 → 0x22. With `stall`=1 the PC holds at 0x20 for 3 cycles, then advances.
- HALT at 0x30 → `halted`=1 and PC holds at 0x30. `resume` with `stall`=1 → no change; `resume` alone → PC 0x32, `halted`=0.
- With checking enabled, STACK_DEPTH=4: 5 nested CALLs → fifth gives `fault`=1, `fault_code`=1, PC frozen, level 4. RET at level 0 → `fault_code`=2.
- `rst_n` low asynchronously mid-CALL while faulted → all outputs 0 before the next clock edge; normal sequencing resumes after release.
